dpram_arbiter: RTL and testbench

- Shares one simple dual-port RAM (port 1 async read from registered address, 1-cycle latency; port 2 registered read data, 2-cycle latency) between three requesters.
- Each cycle: round-robin selection of up to two requests, mapped onto RAM ports 1 and 2.
- Blocks writes to the same address from both ports in one cycle.
- Aligns read responses to a fixed 2-cycle latency regardless of which RAM port served the request.

---
 rtl/dpram_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_dpram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Purpose : shares one simple dual-port RAM between three requesters with round-robin arbitration.
// Latency : writes take effect in the grant cycle; read data returns exactly 2 cycles after the grant.
// Backpr. : reqN_ready is a same-cycle grant; a requester holds its request until it sees ready.
//
// Ports:
//   clk, rst                           single clock; synchronous active-high reset
//   reqN_valid/ready/write/addr/wdata  request channel per requester (N = 0..2)
//   rspN_valid/data                    read response per requester; data holds when not valid
//   mem_port1_*                        RAM port 1 (async read from registered address, 1-cycle read)
//   mem_port2_*                        RAM port 2 (registered read data, 2-cycle read)
//   conflict_cnt                       saturating count of conflict-blocked cycles
//                                      (only when DPRAM_ARB_CONFLICT_CNT_EN is defined)
module dpram_arbiter #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,

  input  logic                  req2_valid,
  output logic                  req2_ready,
  input  logic                  req2_write,
  input  logic [ADDR_WIDTH-1:0] req2_addr,
  input  logic [DATA_WIDTH-1:0] req2_wdata,

  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp2_valid,
  output logic [DATA_WIDTH-1:0] rsp2_data,

  output logic [ADDR_WIDTH-1:0] mem_port1_addr,
  output logic [DATA_WIDTH-1:0] mem_port1_data_in,
  output logic                  mem_port1_write_en,
  input  logic [DATA_WIDTH-1:0] mem_port1_data_out,

  output logic [ADDR_WIDTH-1:0] mem_port2_addr,
  output logic [DATA_WIDTH-1:0] mem_port2_data_in,
  output logic                  mem_port2_write_en,
  input  logic [DATA_WIDTH-1:0] mem_port2_data_out
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  typedef logic [1:0] idx_t;

  function automatic idx_t nxt(input idx_t i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Requester signals gathered into indexable form
  logic [2:0]            req_vld;
  logic [2:0]            req_wr;
  logic [ADDR_WIDTH-1:0] req_addr  [3];
  logic [DATA_WIDTH-1:0] req_wdata [3];

  assign req_vld = {req2_valid, req1_valid, req0_valid};
  assign req_wr  = {req2_write, req1_write, req0_write};

  assign req_addr[0]  = req0_addr;
  assign req_addr[1]  = req1_addr;
  assign req_addr[2]  = req2_addr;
  assign req_wdata[0] = req0_wdata;
  assign req_wdata[1] = req1_wdata;
  assign req_wdata[2] = req2_wdata;

  // Arbitration state
  idx_t rr_ptr_q;
  idx_t rr_ptr_d;

  logic first_found;
  logic second_found;
  idx_t first_idx;
  idx_t second_idx;
  logic conflict;
  logic p1_en;
  logic p2_en;
  idx_t last_idx;
  logic [2:0] gnt;

  // Scan starting at rr_ptr: the first valid requester goes to port 1,
  // the second to port 2, a third one waits.
  always_comb begin
    idx_t scan;
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    scan         = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (req_vld[scan]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = scan;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = scan;
        end
      end
      scan = nxt(scan);
    end
  end

  // Same address with any write involved would race inside the RAM, so the
  // second candidate is held off; the third requester does not take its slot.
  assign conflict = second_found
                 && (req_addr[first_idx] == req_addr[second_idx])
                 && (req_wr[first_idx] || req_wr[second_idx]);

  assign p1_en = first_found && !rst;
  assign p2_en = second_found && !conflict && !rst;

  always_comb begin
    gnt = '0;
    if (p1_en) gnt[first_idx]  = 1'b1;
    if (p2_en) gnt[second_idx] = 1'b1;
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign req2_ready = gnt[2];

  // Pointer moves past the last requester actually served
  always_comb begin
    last_idx = p2_en ? second_idx : first_idx;
    rr_ptr_d = p1_en ? nxt(last_idx) : rr_ptr_q;
  end

  // RAM port drive; an idle port is driven to all zeros
  assign mem_port1_addr     = p1_en ? req_addr[first_idx] : '0;
  assign mem_port1_write_en = p1_en && req_wr[first_idx];
  assign mem_port1_data_in  = mem_port1_write_en ? req_wdata[first_idx] : '0;

  assign mem_port2_addr     = p2_en ? req_addr[second_idx] : '0;
  assign mem_port2_write_en = p2_en && req_wr[second_idx];
  assign mem_port2_data_in  = mem_port2_write_en ? req_wdata[second_idx] : '0;

  // Read tracking pipeline: stage 1 = cycle after grant, stage 2 = response cycle
  logic                  s1_p1_vld_d, s1_p2_vld_d;
  logic                  s1_p1_vld_q, s1_p2_vld_q;
  idx_t                  s1_p1_tag_q, s1_p2_tag_q;
  logic                  s2_p1_vld_q, s2_p2_vld_q;
  idx_t                  s2_p1_tag_q, s2_p2_tag_q;
  logic [DATA_WIDTH-1:0] p1_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_hold_q [3];

  assign s1_p1_vld_d = p1_en && !req_wr[first_idx];
  assign s1_p2_vld_d = p2_en && !req_wr[second_idx];

  // Response steering. Port 1 data was registered one cycle earlier, so both
  // ports line up at grant+2. Port 2 data is passed straight through in that
  // cycle; otherwise each output shows its last delivered word.
  logic [2:0]            rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_dat [3];

  always_comb begin
    rsp_vld = '0;
    for (int n = 0; n < 3; n++) begin
      rsp_dat[n] = rsp_hold_q[n];
      if (!rst && s2_p1_vld_q && (s2_p1_tag_q == idx_t'(n))) begin
        rsp_vld[n] = 1'b1;
        rsp_dat[n] = p1_rdata_q;
      end else if (!rst && s2_p2_vld_q && (s2_p2_tag_q == idx_t'(n))) begin
        rsp_vld[n] = 1'b1;
        rsp_dat[n] = mem_port2_data_out;
      end
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp2_valid = rsp_vld[2];
  assign rsp0_data  = rsp_dat[0];
  assign rsp1_data  = rsp_dat[1];
  assign rsp2_data  = rsp_dat[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      s1_p1_vld_q <= 1'b0;
      s1_p2_vld_q <= 1'b0;
      s1_p1_tag_q <= '0;
      s1_p2_tag_q <= '0;
      s2_p1_vld_q <= 1'b0;
      s2_p2_vld_q <= 1'b0;
      s2_p1_tag_q <= '0;
      s2_p2_tag_q <= '0;
      p1_rdata_q  <= '0;
      for (int n = 0; n < 3; n++) begin
        rsp_hold_q[n] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_p1_vld_q <= s1_p1_vld_d;
      s1_p2_vld_q <= s1_p2_vld_d;
      s1_p1_tag_q <= first_idx;
      s1_p2_tag_q <= second_idx;
      s2_p1_vld_q <= s1_p1_vld_q;
      s2_p2_vld_q <= s1_p2_vld_q;
      s2_p1_tag_q <= s1_p1_tag_q;
      s2_p2_tag_q <= s1_p2_tag_q;
      if (s1_p1_vld_q) begin
        p1_rdata_q <= mem_port1_data_out;
      end
      for (int n = 0; n < 3; n++) begin
        if (rsp_vld[n]) begin
          rsp_hold_q[n] <= rsp_dat[n];
        end
      end
    end
  end

`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic        blocked;
  logic [15:0] conflict_cnt_q;

  assign blocked      = conflict && !rst;
  assign conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (blocked && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_arbiter.sv
// Purpose : directed test of dpram_arbiter against a behavioural dual-port RAM.
// Latency : stimulus driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : requests held until the corresponding ready is seen.
module tb_dpram_arbiter;
  localparam int DW = 14;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req2_valid, req2_ready, req2_write;
  logic [AW-1:0] req2_addr;
  logic [DW-1:0] req2_wdata;
  logic          rsp0_valid, rsp1_valid, rsp2_valid;
  logic [DW-1:0] rsp0_data, rsp1_data, rsp2_data;
  logic [AW-1:0] mem_port1_addr, mem_port2_addr;
  logic [DW-1:0] mem_port1_data_in, mem_port2_data_in;
  logic          mem_port1_write_en, mem_port2_write_en;
  logic [DW-1:0] mem_port1_data_out, mem_port2_data_out;
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0]   conflict_cnt;
`endif

  dpram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req2_valid(req2_valid), .req2_ready(req2_ready), .req2_write(req2_write),
    .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp2_valid(rsp2_valid), .rsp2_data(rsp2_data),
    .mem_port1_addr(mem_port1_addr), .mem_port1_data_in(mem_port1_data_in),
    .mem_port1_write_en(mem_port1_write_en), .mem_port1_data_out(mem_port1_data_out),
    .mem_port2_addr(mem_port2_addr), .mem_port2_data_in(mem_port2_data_in),
    .mem_port2_write_en(mem_port2_write_en), .mem_port2_data_out(mem_port2_data_out)
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Known RAM contents after reset
  function automatic logic [DW-1:0] init_val(input int i);
    return 14'h1000 + DW'(i);
  endfunction

  // Behavioural RAM: port 1 async read from registered address, port 2 registered data
  logic [DW-1:0] mem [64];
  logic [AW-1:0] p1_addr_q, p2_addr_q;
  logic [DW-1:0] p2_dout_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_port1_write_en) mem[mem_port1_addr] <= mem_port1_data_in;
      if (mem_port2_write_en) mem[mem_port2_addr] <= mem_port2_data_in;
    end
    p1_addr_q <= mem_port1_addr;
    p2_addr_q <= mem_port2_addr;
    p2_dout_q <= mem[p2_addr_q];
  end

  assign mem_port1_data_out = mem[p1_addr_q];
  assign mem_port2_data_out = p2_dout_q;

  logic [2:0] rdy, rsp_v;
  assign rdy   = {req2_ready, req1_ready, req0_ready};
  assign rsp_v = {rsp2_valid, rsp1_valid, rsp0_valid};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic w, input int a, input int d);
    case (n)
      0: begin req0_valid = v; req0_write = w; req0_addr = AW'(a); req0_wdata = DW'(d); end
      1: begin req1_valid = v; req1_write = w; req1_addr = AW'(a); req1_wdata = DW'(d); end
      default: begin req2_valid = v; req2_write = w; req2_addr = AW'(a); req2_wdata = DW'(d); end
    endcase
  endtask

  task automatic idle();
    for (int n = 0; n < 3; n++) set_req(n, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rsp_dat(input int n);
    case (n)
      0: return rsp0_data;
      1: return rsp1_data;
      default: return rsp2_data;
    endcase
  endfunction

  int gcnt [3];
  int rcnt [3];
  int gap  [3];
  int maxgap;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    idle();
    set_req(0, 1'b1, 1'b1, 5, 14'h0555);
    @(negedge clk);
    chk("rst_ready", rdy, 3'b000);
    chk("rst_we1", mem_port1_write_en, 1'b0);
    chk("rst_we2", mem_port2_write_en, 1'b0);
    next_cycle();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_rspv", rsp_v, 3'b000);
    chk("rst_rsp0d", rsp0_data, 0);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("rst_ccnt", conflict_cnt, 0);
`endif

    // ---------------- write then read, req0 ----------------
    next_cycle();
    set_req(0, 1'b1, 1'b1, 5, 14'h1ABC);           // rr=0
    @(negedge clk);
    chk("wr_ready", rdy, 3'b001);
    chk("wr_we1", mem_port1_write_en, 1'b1);
    chk("wr_a1", mem_port1_addr, 5);
    chk("wr_d1", mem_port1_data_in, 14'h1ABC);
    chk("wr_we2", mem_port2_write_en, 1'b0);
    chk("wr_a2", mem_port2_addr, 0);
    next_cycle();
    idle();
    next_cycle();
    set_req(0, 1'b1, 1'b0, 5, 0);                  // rr=1
    @(negedge clk);
    chk("rd_ready", rdy, 3'b001);
    chk("rd_a1", mem_port1_addr, 5);
    chk("rd_we1", mem_port1_write_en, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_t1_v", rsp_v, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("rd_t2_v", rsp_v, 3'b001);
    chk("rd_t2_d", rsp0_data, 14'h1ABC);
    next_cycle();
    @(negedge clk);
    chk("rd_t3_v", rsp_v, 3'b000);
    chk("rd_hold", rsp0_data, 14'h1ABC);

    // bring rr_ptr to 0: lone grant of req2
    next_cycle();
    set_req(2, 1'b1, 1'b1, 10, 14'h0333);          // rr=1 -> 0
    @(negedge clk);
    chk("rr0_ready", rdy, 3'b100);
    next_cycle();

    // ---------------- three reads, rr=0 ----------------
    set_req(0, 1'b1, 1'b0, 1, 0);
    set_req(1, 1'b1, 1'b0, 2, 0);
    set_req(2, 1'b1, 1'b0, 3, 0);
    @(negedge clk);
    chk("rr3_c0_ready", rdy, 3'b011);
    chk("rr3_c0_a1", mem_port1_addr, 1);
    chk("rr3_c0_a2", mem_port2_addr, 2);
    next_cycle();
    set_req(0, 1'b0, 1'b0, 0, 0);
    set_req(1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("rr3_c1_ready", rdy, 3'b100);
    chk("rr3_c1_a1", mem_port1_addr, 3);
    chk("rr3_c1_a2", mem_port2_addr, 0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rr3_rsp_v0", rsp_v, 3'b011);
    chk("rr3_rsp0_d", rsp0_data, init_val(1));
    chk("rr3_rsp1_d", rsp1_data, init_val(2));
    next_cycle();
    @(negedge clk);
    chk("rr3_rsp_v1", rsp_v, 3'b100);
    chk("rr3_rsp2_d", rsp2_data, init_val(3));

    // bring rr_ptr to 1: lone grant of req0 (rr=0 -> 1)
    next_cycle();
    set_req(0, 1'b1, 1'b1, 11, 14'h0444);
    @(negedge clk);
    chk("rr1_ready", rdy, 3'b001);
    next_cycle();
    idle();

    // ---------------- write/write conflict on addr 9, rr=1 ----------------
    set_req(1, 1'b1, 1'b1, 9, 14'h1111);
    set_req(2, 1'b1, 1'b1, 9, 14'h2222);
    @(negedge clk);
    chk("cf_c0_ready", rdy, 3'b010);
    chk("cf_c0_a1", mem_port1_addr, 9);
    chk("cf_c0_d1", mem_port1_data_in, 14'h1111);
    chk("cf_c0_we2", mem_port2_write_en, 1'b0);
    chk("cf_c0_a2", mem_port2_addr, 0);
    next_cycle();
    set_req(1, 1'b0, 1'b0, 0, 0);                  // rr=2
    @(negedge clk);
    chk("cf_c1_ready", rdy, 3'b100);
    chk("cf_c1_d1", mem_port1_data_in, 14'h2222);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("cf_ccnt", conflict_cnt, 1);
`endif
    next_cycle();
    idle();
    set_req(0, 1'b1, 1'b0, 9, 0);                  // rr=0 -> 1
    @(negedge clk);
    chk("cf_rd_ready", rdy, 3'b001);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    chk("cf_rd_v", rsp_v, 3'b001);
    chk("cf_mem9", rsp0_data, 14'h2222);

    // ---------------- read/read same address, rr=1 ----------------
    next_cycle();
    set_req(0, 1'b1, 1'b0, 7, 0);
    set_req(1, 1'b1, 1'b0, 7, 0);
    @(negedge clk);
    chk("rr_same_ready", rdy, 3'b011);
    chk("rr_same_a1", mem_port1_addr, 7);
    chk("rr_same_a2", mem_port2_addr, 7);
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    chk("rr_same_v", rsp_v, 3'b011);
    chk("rr_same_d0", rsp0_data, init_val(7));
    chk("rr_same_d1", rsp1_data, init_val(7));
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("rr_same_ccnt", conflict_cnt, 1);
`endif

    // ---------------- fairness: all three reading for 6 cycles ----------------
    next_cycle();
    for (int n = 0; n < 3; n++) begin
      gcnt[n] = 0; rcnt[n] = 0; gap[n] = 0;
      set_req(n, 1'b1, 1'b0, 20 + n, 0);
    end
    maxgap = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) idle();
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        if (c < 6) begin
          if (rdy[n]) begin
            gcnt[n]++;
            gap[n] = 0;
          end else begin
            gap[n]++;
            if (gap[n] > maxgap) maxgap = gap[n];
          end
        end
        if (rsp_v[n]) begin
          rcnt[n]++;
          chk("fair_rsp_d", 32'(rsp_dat(n)), 32'(init_val(20 + n)));
        end
      end
      next_cycle();
    end
    chk("fair_g0", gcnt[0], 4);
    chk("fair_g1", gcnt[1], 4);
    chk("fair_g2", gcnt[2], 4);
    chk("fair_r0", rcnt[0], 4);
    chk("fair_r1", rcnt[1], 4);
    chk("fair_r2", rcnt[2], 4);
    chk("fair_maxgap", maxgap, 1);

    // ---------------- reset one cycle after a read grant (rr=1) ----------------
    set_req(0, 1'b1, 1'b0, 5, 0);
    @(negedge clk);
    chk("rst2_grant", rdy, 3'b001);
    next_cycle();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) set_req(n, 1'b1, 1'b0, 30 + n, 0);
    @(negedge clk);
    chk("rst2_ready", rdy, 3'b000);
    chk("rst2_we1", mem_port1_write_en, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_rspv", rsp_v, 3'b000);
    chk("rst2_rsp0d", rsp0_data, 0);
    chk("rst2_ready_post", rdy, 3'b011);
    chk("rst2_a1", mem_port1_addr, 30);
    chk("rst2_a2", mem_port2_addr, 31);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("rst2_ccnt", conflict_cnt, 0);
`endif
    next_cycle();
    idle();
    @(negedge clk);
    chk("rst2_rspv_t1", rsp_v, 3'b000);
    next_cycle();
    @(negedge clk);
    chk("rst2_rspv_t2", rsp_v, 3'b011);
    chk("rst2_rsp0_d", rsp0_data, init_val(30));
    chk("rst2_rsp1_d", rsp1_data, init_val(31));
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
